// File: rtl/serial_tx.sv
// UART-style serial transmitter: one start bit, DATA_BITS data bits LSB first, one stop bit.
// A request is taken on any clock edge where start and ready are both high; tx comes from a register.
module serial_tx #(
    parameter int DIVISOR   = 104,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 start,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx
);

    localparam int DIVW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int BITW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e                 state_q, state_d;
    logic [DIVW-1:0]        divCnt_q, divCnt_d;
    logic [BITW-1:0]        bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0]   shiftReg_q, shiftReg_d;
    logic                   tx_q, tx_d;
    logic                   bitDone;

    assign bitDone = (divCnt_q == DIVW'(DIVISOR - 1));
    assign ready   = (state_q == IDLE);
    assign busy    = ~ready;
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            divCnt_q   <= '0;
            bitCnt_q   <= '0;
            shiftReg_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            bitCnt_q   <= bitCnt_d;
            shiftReg_q <= shiftReg_d;
            tx_q       <= tx_d;
        end
    end

    // tx_d is the line level for the next cycle, so every bit boundary loads the next bit value here.
    always_comb begin
        state_d    = state_q;
        divCnt_d   = bitDone ? '0 : divCnt_q + 1'b1;
        bitCnt_d   = bitCnt_q;
        shiftReg_d = shiftReg_q;
        tx_d       = tx_q;

        case (state_q)
            IDLE: begin
                divCnt_d = '0;
                tx_d     = 1'b1;
                if (start) begin
                    state_d    = START;
                    shiftReg_d = data;
                    bitCnt_d   = '0;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (bitDone) begin
                    state_d  = DATA;
                    bitCnt_d = '0;
                    tx_d     = shiftReg_q[0];
                end
            end
            DATA: begin
                if (bitDone) begin
                    shiftReg_d = shiftReg_q >> 1;
                    bitCnt_d   = bitCnt_q + 1'b1;
                    if (bitCnt_q == BITW'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shiftReg_q[1];
                    end
                end
            end
            STOP: begin
                if (bitDone) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: directed and randomized requests compared cycle by cycle against a
// frame-level reference model that expands each accepted word into its expected line levels.
module tb_serial_tx;

    localparam int DIV   = 4;
    localparam int DB    = 8;
    localparam int FRAME = (DB + 2) * DIV;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DB-1:0] data  = '0;
    logic          ready;
    logic          busy;
    logic          tx;

    int checks = 0;
    int errors = 0;
    int busyLen;

    // Remaining expected line levels of the frame in flight; empty means idle.
    bit expQ[$];

    serial_tx #(
        .DIVISOR  (DIV),
        .DATA_BITS(DB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .data (data),
        .start(start),
        .ready(ready),
        .busy (busy),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    // Each cycle consumes one queued level; an empty queue at an edge with start pushes a whole frame.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            expQ.delete();
        end else if (expQ.size() != 0) begin
            void'(expQ.pop_front());
        end else if (start) begin
            for (int i = 0; i < DIV; i++) expQ.push_back(1'b0);
            for (int b = 0; b < DB; b++)
                for (int i = 0; i < DIV; i++) expQ.push_back(data[b]);
            for (int i = 0; i < DIV; i++) expQ.push_back(1'b1);
        end
    end

    task automatic checkOutput(input string tag);
        logic expTx;
        logic expReady;
        expReady = (expQ.size() == 0);
        expTx    = expReady ? 1'b1 : expQ[0];
        checks++;
        assert (tx === expTx) else begin
            errors++;
            $error("FAIL %s tx: observed %b expected %b", tag, tx, expTx);
        end
        checks++;
        assert (ready === expReady) else begin
            errors++;
            $error("FAIL %s ready: observed %b expected %b", tag, ready, expReady);
        end
        checks++;
        assert (busy === ~expReady) else begin
            errors++;
            $error("FAIL %s busy: observed %b expected %b", tag, busy, ~expReady);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [DB-1:0] d);
        start = s;
        data  = d;
    endtask

    task automatic tick(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    initial begin
        int w;
        int n;
        $display("[TB] serial_tx bench, DIVISOR=%0d DATA_BITS=%0d", DIV, DB);

        // Reset asserted with a pending request: outputs idle immediately and stay idle.
        applyStimulus(1'b1, 8'hFF);
        #1 reset = 1'b0;
        #1 checkOutput("reset_async");
        tick("reset_hold", 5);
        applyStimulus(1'b0, 8'hFF);
        reset = 1'b1;
        tick("post_reset", 6);

        // Single frame 0xA3, with the busy window measured directly.
        applyStimulus(1'b1, 8'hA3);
        busyLen = 0;
        tick("a3", 1);
        if (busy) busyLen++;
        applyStimulus(1'b0, 8'h00);
        repeat (FRAME + 4) begin
            tick("a3", 1);
            if (busy) busyLen++;
        end
        checks++;
        assert (busyLen == FRAME) else begin
            errors++;
            $error("FAIL a3_busy_len: observed %0d expected %0d", busyLen, FRAME);
        end

        // Request during a frame is dropped.
        applyStimulus(1'b1, 8'h55);
        tick("ign", 1);
        applyStimulus(1'b0, 8'h55);
        tick("ign", 10);
        applyStimulus(1'b1, 8'h0F);
        tick("ign", 1);
        applyStimulus(1'b0, 8'h0F);
        tick("ign", FRAME + 4);

        // Start held high: back-to-back frames 0x00 then 0xFF.
        applyStimulus(1'b1, 8'h00);
        tick("b2b", 1);
        applyStimulus(1'b1, 8'hFF);
        tick("b2b", 2 * FRAME + 5);
        applyStimulus(1'b0, 8'hFF);
        tick("b2b", FRAME + 4);

        // Data changing after acceptance must not affect the frame.
        applyStimulus(1'b1, 8'h3C);
        tick("stab", 1);
        applyStimulus(1'b0, 8'hC3);
        tick("stab", FRAME + 4);

        // Reset during data bit 3, then a fresh 0x81 frame.
        applyStimulus(1'b1, 8'hA5);
        tick("midrst", 1);
        applyStimulus(1'b0, 8'hA5);
        tick("midrst", 17);
        #2 reset = 1'b0;
        #1 checkOutput("midrst_async");
        applyStimulus(1'b1, 8'hFF);
        tick("midrst_hold", 3);
        reset = 1'b1;
        applyStimulus(1'b1, 8'h81);
        tick("fresh81", 1);
        applyStimulus(1'b0, 8'h81);
        tick("fresh81", FRAME + 4);

        // Randomized requests, hold widths and stray mid-frame pulses.
        for (int k = 0; k < 10; k++) begin
            w = $urandom_range(1, 3);
            applyStimulus(1'b1, DB'($urandom));
            tick("rand", w);
            applyStimulus(1'b0, DB'($urandom));
            n = $urandom_range(1, 30);
            tick("rand", n);
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(1'b1, DB'($urandom));
                tick("rand_stray", 1);
                applyStimulus(1'b0, data);
            end
            tick("rand", FRAME + 2);
            tick("rand_gap", $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Serial transmitter that drives a single-wire, UART-style line: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
- Serializing counterpart of the D-flip-flop sampling stage that captures the line on the receive side.
- Sits between a parallel byte source (FSM or button logic) and an FPGA output pin.
- Uses a simple start/ready handshake.

Parameters:
DIVISOR, 104, clock cycles per bit (12 MHz / 115200 baud); minimum 2
DATA_BITS, 8, data bits per frame; range 5..9

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
data  input  DATA_BITS  parallel word to transmit; sampled only on acceptance
start  input  1  transmit request; accepted on a rising clk edge where start=1 and ready=1
ready  output  1  1 = idle, able to accept a request
busy  output  1  1 = frame in progress; always equals ~ready
tx  output  1  serial line; idles high

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, ready=1, busy=0, bit counter=0, divider counter=0, shift register=0. Outputs take these values immediately, with no clock edge required. State is held while reset=0.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, ready=1.
  - On an edge with start=1, latch data into the shift register, clear the divider, and go to START.
  - ready=0 and tx=0 from the cycle after that edge. Latency from acceptance to the start bit on tx is 1 cycle.
- START: tx=0 for exactly DIVISOR cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit 0; each bit is held DIVISOR cycles.
  - After each bit, shift right and increment the bit index.
  - After bit DATA_BITS-1, go to STOP.
- STOP: tx=1 for exactly DIVISOR cycles, then go to IDLE. ready=1 in the cycle after the last stop-bit cycle.
- Frame length: (DATA_BITS+2)*DIVISOR cycles from the first start-bit cycle to the return to IDLE.
- Handshake rules:
  - start while busy=1 is ignored, not queued.
  - start held high continuously produces back-to-back frames, with exactly 1 idle-high cycle (the IDLE acceptance cycle) between frames.
  - data changes after acceptance have no effect on the frame in flight.
- tx is driven from a register, so it is glitch-free.
- Divider counts 0..DIVISOR-1 and wraps; the bit boundary occurs on the wrap.
- Divider width is ceil(log2(DIVISOR)); bit counter width is ceil(log2(DATA_BITS+1)).
- Reset mid-frame: the frame is aborted, tx=1 immediately, ready=1. The first request after reset release starts a fresh frame.
- Reset released on the same edge that start=1 is present: the request is accepted at that edge only if reset was already 1 before the edge. Otherwise it is accepted on the next edge.

Test Plan (DIVISOR=4, DATA_BITS=8):
- Reset check: reset=0 with start=1, data=0xFF -> tx=1, ready=1, busy=0 throughout; no frame appears after reset=1 until start is pulsed again.
- Single frame 0xA3: pulse start for 1 cycle -> tx shows 0 (4 cycles), bits 1,1,0,0,0,1,0,1 (4 cycles each), then 1 (4 cycles); busy=1 for 40 cycles; ready returns on cycle 41.
- Ignored request: mid-frame of 0x55, pulse start with data=0x0F -> frame continues as 0x55; no second frame follows.
- Back-to-back: start held high, data=0x00 then 0xFF -> two 40-cycle frames separated by exactly 1 cycle of tx=1; second frame data bits all 1.
- Data stability: accept 0x3C, then change data to 0xC3 on the next cycle -> transmitted bits are 0,0,1,1,1,1,0,0.
- Reset mid-frame: reset=0 during data bit 3 -> tx=1 and ready=1 asynchronously. After release, a start with 0x81 yields a complete, correct 40-cycle frame.
